// File: rtl/add_sched_pkg.sv
// Shared types and defaults for the round-robin adder scheduler.
package add_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 32;

endpackage

// File: rtl/add_all1.sv
// 32-bit ripple-carry adder, purely combinational.
module add_all1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  always_comb begin
    carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[W];
  end

endmodule

// File: rtl/add_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module add_rr_pick
  import add_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic [IW-1:0] j;

  // N_REQ is a power of two, so ptr + k wraps modulo N_REQ for free.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = ptr + IW'(k);
      if (!any && req_valid[j]) begin
        any      = 1'b1;
        idx      = j;
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_sched.sv
// Shares one ripple adder among N_REQ requesters; SUB takes two passes (a + ~b, then +1).
module add_sched
  import add_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*W-1:0]         req_a,
  input  logic [N_REQ*W-1:0]         req_b,
  input  logic [N_REQ-1:0]           req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [W-1:0]               rsp_sum,
  output logic                       rsp_cout,
  output logic                       busy
);

  localparam int IW = $clog2(N_REQ);

  state_t         state;
  logic [IW-1:0]  ptr;
  logic [W-1:0]   a_r, b_r, sum1_r;
  logic           op_r, c1_r;
  logic [IW-1:0]  id_r;

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    gidx;
  logic             gany;

  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cout;

  add_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .idx       (gidx),
    .any       (gany)
  );

  add_all1 #(.W(W)) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign req_ready = (!rst && state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);

  // Adder inputs are held at zero outside the two passes.
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      PASS1: begin
        add_a = a_r;
        add_b = (op_r == OP_SUB) ? ~b_r : b_r;
      end
      PASS2: begin
        add_a = sum1_r;
        add_b = W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gany) begin
            a_r   <= req_a[gidx*W +: W];
            b_r   <= req_b[gidx*W +: W];
            op_r  <= req_op[gidx];
            id_r  <= gidx;
            ptr   <= gidx + IW'(1);
            state <= PASS1;
          end
        end
        PASS1: begin
          sum1_r <= add_sum;
          c1_r   <= add_cout;
          if (op_r == OP_SUB) begin
            state <= PASS2;
          end else begin
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
            rsp_id    <= id_r;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        PASS2: begin
          // Either pass carrying out means no borrow occurred.
          rsp_sum   <= add_sum;
          rsp_cout  <= c1_r | add_cout;
          rsp_id    <= id_r;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sched.sv
// Directed self-checking bench for add_sched with hand-computed vectors.
module tb_add_sched;

  localparam int N = 4;
  localparam int W = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N-1:0]    req_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_sum;
  logic            rsp_cout;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  add_sched #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_id", rsp_id, 0);
    req_valid = '0;
    rst       = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input string tag, input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] es, input logic ec, input int elat);
    int lat;
    logic [N-1:0] exp_gnt;
    exp_gnt = '0;
    exp_gnt[id] = 1'b1;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_op[id]       = op;
    req_valid[id]    = 1'b1;
    #1;
    chk({tag, "_gnt"}, req_ready, exp_gnt);
    @(negedge clk);
    req_valid[id] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_sum"}, rsp_sum, es);
    chk({tag, "_cout"}, rsp_cout, ec);
    chk({tag, "_id"}, rsp_id, id);
    @(negedge clk);
    chk({tag, "_done"}, rsp_valid, 0);
  endtask

  initial begin
    int gorder[5];
    int gcyc[5];
    int ng, cyc, lat, rr_bad, gi;
    logic seen;
    logic [N-1:0] g;

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    do_reset();

    run_op("add_small", 0, 32'h5, 32'h3, 1'b0, 32'h8, 1'b0, 2);
    run_op("add_carry", 2, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 2);
    run_op("sub_noborrow", 1, 32'h10, 32'h3, 1'b1, 32'hD, 1'b1, 3);
    run_op("sub_borrow", 3, 32'h3, 32'h10, 1'b1, 32'hFFFF_FFF3, 1'b0, 3);
    run_op("sub_bzero", 0, 32'h0000_1234, 32'h0, 1'b1, 32'h0000_1234, 1'b1, 3);
    run_op("sub_equal", 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b1, 3);

    // Round-robin with every requester asserting continuously.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'h100 * i;
      req_b[i*W +: W] = i;
      req_op[i]       = 1'b0;
    end
    req_valid = '1;
    ng = 0;
    cyc = 0;
    rr_bad = 0;
    while (ng < 5 && cyc < 60) begin
      #1;
      if (req_ready != 0) begin
        g = req_ready;
        gi = 0;
        for (int k = 0; k < N; k++) if (g[k]) gi = k;
        gorder[ng] = gi;
        gcyc[ng]   = cyc;
        ng++;
      end
      if (rsp_valid && rsp_sum != (32'h100 * rsp_id + rsp_id)) rr_bad++;
      @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    chk("rr_count", ng, 5);
    chk("rr_g0", gorder[0], 0);
    chk("rr_g1", gorder[1], 1);
    chk("rr_g2", gorder[2], 2);
    chk("rr_g3", gorder[3], 3);
    chk("rr_g4", gorder[4], 0);
    chk("rr_spacing", gcyc[4] - gcyc[0], 12);
    chk("rr_rsp_sums", rr_bad, 0);
    repeat (4) @(negedge clk);

    // Backpressure: hold rsp_ready low for 5 cycles in RESP.
    rsp_ready = 1'b0;
    req_a[1*W +: W] = 32'h1111_1111;
    req_b[1*W +: W] = 32'h2222_2222;
    req_op[1] = 1'b0;
    req_a[2*W +: W] = 32'h7;
    req_b[2*W +: W] = 32'h8;
    req_op[2] = 1'b0;
    req_valid[1] = 1'b1;
    #1;
    chk("bp_gnt1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    req_valid[2] = 1'b1;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", lat, 1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_sum", rsp_sum, 32'h3333_3333);
      chk("bp_hold_id", rsp_id, 1);
      chk("bp_no_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_idle", busy, 0);
    chk("bp_gnt2", req_ready, 4'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("bp2_lat", lat, 2);
    chk("bp2_sum", rsp_sum, 32'hF);
    chk("bp2_id", rsp_id, 2);
    @(negedge clk);

    // Reset during PASS2 of a SUB drops the operation.
    req_a[3*W +: W] = 32'h50;
    req_b[3*W +: W] = 32'h20;
    req_op[3] = 1'b1;
    req_valid[3] = 1'b1;
    #1;
    chk("mid_gnt", req_ready, 4'b1000);
    @(negedge clk);
    req_valid[3] = 1'b0;
    @(negedge clk);
    chk("mid_busy_pass2", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_valid", rsp_valid, 0);
    chk("mid_sum", rsp_sum, 0);
    chk("mid_id", rsp_id, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_no_rsp", seen, 0);
    req_valid = '1;
    #1;
    chk("mid_ptr0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
